dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port A (core load/store) and port B (debug/DMA loader).
- Selects one requester, latches its command and drives the memory's addr/dataIn/memoryEnable/readNotWrite inputs for exactly one cycle.
- Returns the memory's registered dataOut to the winning requester with a one-cycle done strobe.
- Sits between the pipeline's memory stage and the data memory.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 85 ++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for the two-port data memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              done_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              done_b;
    logic [DATA_W-1:0] rdata_b;

    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dataIn;
    logic              mem_enable;
    logic              mem_readNotWrite;
    logic [DATA_W-1:0] mem_dataOut;

    // Arbiter side.
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        output done_a, rdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output done_b, rdata_b,
        output busy,
        output mem_addr, mem_dataIn, mem_enable, mem_readNotWrite,
        input  mem_dataOut
    );

    // Requesters plus memory side.
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        input  done_a, rdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  done_b, rdata_b,
        input  busy,
        input  mem_addr, mem_dataIn, mem_enable, mem_readNotWrite,
        output mem_dataOut
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: one access per
// IDLE -> ISSUE -> RESP sequence, round-robin or fixed priority on ties.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state, stateNext;
    logic              owner, ownerNext;        // 0 = A, 1 = B
    logic              lastGrant, lastGrantNext;
    logic [ADDR_W-1:0] addrQ, addrNext;
    logic [DATA_W-1:0] dataQ, dataNext;
    logic              weQ, weNext;
    logic              pickB;

    // State, ownership and latched command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lastGrant <= 1'b1;
            addrQ     <= '0;
            dataQ     <= '0;
            weQ       <= 1'b0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastGrant <= lastGrantNext;
            addrQ     <= addrNext;
            dataQ     <= dataNext;
            weQ       <= weNext;
        end
    end

    // Arbitration, next state and output decode from registered state only.
    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        lastGrantNext = lastGrant;
        addrNext      = addrQ;
        dataNext      = dataQ;
        weNext        = weQ;
        pickB         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    // B wins when alone, or on a round-robin tie after an A grant.
                    pickB         = bus.req_b && (!bus.req_a || (!FIXED_PRI && !lastGrant));
                    ownerNext     = pickB;
                    lastGrantNext = pickB;
                    addrNext      = pickB ? bus.addr_b  : bus.addr_a;
                    dataNext      = pickB ? bus.wdata_b : bus.wdata_a;
                    weNext        = pickB ? bus.we_b    : bus.we_a;
                    stateNext     = ISSUE;
                end
            end
            ISSUE:   stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        bus.busy             = (state != IDLE);
        bus.mem_addr         = addrQ;
        bus.mem_dataIn       = dataQ;
        bus.mem_enable       = (state == ISSUE);
        bus.mem_readNotWrite = !((state == ISSUE) && weQ);
        bus.done_a           = (state == RESP) && !owner;
        bus.done_b           = (state == RESP) && owner;
        bus.rdata_a          = ((state == RESP) && !owner) ? bus.mem_dataOut : '0;
        bus.rdata_b          = ((state == RESP) && owner)  ? bus.mem_dataOut : '0;
    end

endmodule
